// File: rtl/adder_arb_pkg.sv
// Shared types for the two-requester adder arbiter: default width, FSM states, requester id.
package adder_arb_pkg;
    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;
endpackage

// File: rtl/adder_arb_rr.sv
// Combinational two-way round-robin picker: on contention the requester not granted last wins.
module adder_arb_rr
    import adder_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output req_id_t    grant,
    output logic       grant_valid
);
    always_comb begin
        grant_valid = |valid;
        if (valid == 2'b11) grant = ~last_grant;
        else                grant = valid[0] ? 1'b0 : 1'b1;
    end
endmodule

// File: rtl/adder_arbiter.sv
// Arbitrates two requesters onto one external sixteenbit_adder (IDLE -> EXEC -> RESP).
// Optional ADDER_ARB_STATS_EN adds saturating grant/overflow counters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_ovf,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_f,
    input  logic             add_ovf,
    output logic             busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [15:0]      ovf_cnt
`endif
);
    state_t  state, state_nxt;
    req_id_t last_grant, owner, pick;
    logic    pick_valid, accept;

    adder_arb_rr u_rr (
        .valid       (req_valid),
        .last_grant  (last_grant),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    // Everything is gated by rst so a reset cycle never shows a handshake.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        accept         = 1'b1;
                        req_ready[pick] = 1'b1;
                        state_nxt      = EXEC;
                    end
                end
                EXEC: begin
                    busy      = 1'b1;
                    state_nxt = RESP;
                end
                RESP: begin
                    busy              = 1'b1;
                    resp_valid[owner] = 1'b1;
                    if (resp_ready[owner]) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            resp_sum   <= '0;
            resp_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= pick;
                owner      <= pick;
                add_a      <= pick ? req_a1 : req_a0;
                add_b      <= pick ? req_b1 : req_b0;
            end
            if (state == EXEC) begin
                resp_sum <= add_f;
                resp_ovf <= add_ovf;
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            ovf_cnt    <= '0;
        end else begin
            if (accept && !pick && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (accept &&  pick && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
            if (state == EXEC && add_ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; all data ports below are WIDTH bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  out  2  per-requester request accept.
REQ-006 req_a0, req_b0  in  WIDTH  requester 0 operands.
REQ-007 req_a1, req_b1  in  WIDTH  requester 1 operands.
REQ-008 resp_valid  out  2  per-requester result valid.
REQ-009 resp_ready  in  2  per-requester result accept.
REQ-010 resp_sum  out  WIDTH  result, shared by both requesters; qualified by resp_valid.
REQ-011 resp_ovf  out  1  signed-overflow flag of the result.
REQ-012 add_a, add_b  out  WIDTH  registered operands driven to the external sixteenbit_adder.
REQ-013 add_f  in  WIDTH  sum from the adder, combinational from add_a/add_b.
REQ-014 add_ovf  in  1  overflow flag from the adder.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid bit is set, one requester is granted, req_ready is set for that requester only (combinational), operands are latched into add_a/add_b, and the state goes to EXEC.
REQ-018 req_ready is 0 in EXEC and RESP; at most one req_ready bit is set in any cycle.
REQ-019 Arbitration is round-robin: a single request is granted; when both request, the grant goes to the requester not granted last; last_grant updates on each accept.
REQ-020 EXEC lasts exactly one cycle; at its end, add_f goes to resp_sum, add_ovf goes to resp_ovf, and the state goes to RESP.
REQ-021 RESP: resp_valid[g] is 1 for the granted requester g only; sum and ovf are held stable until resp_ready[g]=1, after which the state returns to IDLE.
REQ-022 resp_ready of the non-granted requester is ignored.
REQ-023 Latency: accept in cycle T; resp_valid is high in cycle T+2; minimum of 3 cycles per operation.
REQ-024 add_a/add_b hold their last operands outside accept cycles; there is no width extension; wrap-around is modulo 2^WIDTH, as produced by the adder.
REQ-025 A req_valid deassertion during EXEC/RESP has no effect on the in-flight operation.

Reset
REQ-026 rst has priority over all other inputs, mid-operation included: any in-flight operation is discarded and no response is issued.
REQ-027 Reset values: state=IDLE, last_grant=1 (requester 0 wins the first contention), add_a=add_b=0, resp_sum=0, resp_ovf=0, resp_valid=0.
REQ-028 In the reset cycle req_ready=0 and busy=0.

Configuration
REQ-029 ADDER_ARB_STATS_EN defined: adds outputs grant_cnt0, grant_cnt1, ovf_cnt (16 bits each).
REQ-030 grant_cnt0/grant_cnt1 increment on accepts per requester; ovf_cnt increments on each EXEC capture with add_ovf=1.
REQ-031 All three counters saturate at 0xFFFF and clear on rst.
REQ-032 ADDER_ARB_STATS_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package adder_arb_pkg holds the WIDTH default constant, the FSM state enum, and the requester-id typedef (1 bit).
REQ-034 One sub-module, adder_arb_rr: a combinational round-robin picker (inputs: valid[1:0] and last_grant; outputs: grant id and grant_valid).
REQ-035 The adder itself is not instantiated inside; the top level wires add_* to sixteenbit_adder.

Verification
REQ-036 Requester 0 only, a=0x0003, b=0x0004 -> req_ready[0] at T, resp_valid[0] at T+2, sum=0x0007, ovf=0.
REQ-037 Requester 1, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1; with STATS_EN, ovf_cnt=1.
REQ-038 Both valid every cycle after reset -> grant order 0,1,0,1; a=0xFFFF, b=0x0001 gives sum=0x0000, ovf=0.
REQ-039 RESP with resp_ready[g]=0 for 5 cycles -> sum/valid held 5 cycles, req_ready=0 throughout, IDLE one cycle after resp_ready.
REQ-040 rst asserted in EXEC -> next cycle IDLE, resp_valid=0 never pulses, add_a=add_b=0, requester 0 wins the next contention.
REQ-041 STATS_EN with 0x10000 requester-0 accepts forced via preload -> grant_cnt0 stays at 0xFFFF.
